// File: rtl/paged_memory_unit_if.sv
// Request/response bus between the core load/store path and paged_memory_unit.
// Signals:
//   req_valid, req_write, req_select_byte, req_address, req_data  master -> slave
//   req_ready, rsp_valid, rsp_data, rsp_error, busy                slave -> master
interface paged_memory_unit_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 16
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic                  req_select_byte;
   logic [ADDR_WIDTH-1:0] req_address;
   logic [DATA_WIDTH-1:0] req_data;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  rsp_error;
   logic                  busy;

   modport master (
      output req_valid, req_write, req_select_byte, req_address, req_data,
      input  req_ready, rsp_valid, rsp_data, rsp_error, busy
   );

   modport slave (
      input  req_valid, req_write, req_select_byte, req_address, req_data,
      output req_ready, rsp_valid, rsp_data, rsp_error, busy
   );
endinterface

// File: rtl/paged_memory_unit.sv
// Byte-addressable data memory with word and byte access over a valid/ready
// request port. Responses are registered one cycle after accept. After reset the
// array is cleared to INIT_BYTE, one word per cycle, while busy is high.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high; restarts the clear and drops any response
//   bus    paged_memory_unit_if slave: request, response, busy
module paged_memory_unit #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DEPTH_BYTES = 64,
   parameter logic [7:0]  INIT_BYTE   = 8'h00
) (
   input logic               clock,
   input logic               reset,
   paged_memory_unit_if.slave bus
);
   localparam int unsigned BPW   = DATA_WIDTH / 8;
   localparam int unsigned WORDS = DEPTH_BYTES / BPW;
   localparam int unsigned OFS   = $clog2(BPW);
   localparam int unsigned IDXW  = ADDR_WIDTH - OFS;
   localparam int unsigned MW    = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [0:0] {StClear, StReady} state_t;

   state_t                state;
   logic [MW-1:0]         clr_cnt;
   logic [DATA_WIDTH-1:0] mem [WORDS];

   logic [IDXW-1:0] word_idx;
   logic [OFS-1:0]  lane;
   logic [MW-1:0]   mem_idx;
   logic            in_range;
   logic            accept;

   assign word_idx = bus.req_address[ADDR_WIDTH-1:OFS];
   assign lane     = bus.req_address[OFS-1:0];
   assign mem_idx  = word_idx[MW-1:0];
   // Compare on the full index, so high addresses never alias into the array.
   assign in_range = ({1'b0, word_idx} < (IDXW + 1)'(WORDS));
   assign accept   = bus.req_valid && bus.req_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= StClear;
         clr_cnt       <= '0;
         bus.req_ready <= 1'b0;
         bus.busy      <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_error <= 1'b0;
         bus.rsp_data  <= '0;
      end else begin
         unique case (state)
            StClear: begin
               mem[clr_cnt]  <= {BPW{INIT_BYTE}};
               clr_cnt       <= clr_cnt + 1'b1;
               bus.rsp_valid <= 1'b0;
               bus.rsp_error <= 1'b0;
               bus.rsp_data  <= '0;
               if (clr_cnt == MW'(WORDS - 1)) begin
                  state         <= StReady;
                  bus.req_ready <= 1'b1;
                  bus.busy      <= 1'b0;
               end
            end
            StReady: begin
               bus.rsp_valid <= accept;
               bus.rsp_error <= accept && !in_range;
               bus.rsp_data  <= '0;
               if (accept && in_range) begin
                  if (bus.req_write) begin
                     if (bus.req_select_byte) begin
                        mem[mem_idx][{lane, 3'b000} +: 8] <= bus.req_data[7:0];
                     end else begin
                        mem[mem_idx] <= bus.req_data;
                     end
                  end else if (bus.req_select_byte) begin
                     bus.rsp_data <= DATA_WIDTH'(mem[mem_idx][{lane, 3'b000} +: 8]);
                  end else begin
                     bus.rsp_data <= mem[mem_idx];
                  end
               end
            end
            default: state <= StClear;
         endcase
      end
   end
endmodule
